muldiv_ctrl: RTL

Iterative multiply/divide sequencer for the EX stage. It executes MULT, MULTU, DIV and DIVU over 34 cycles and owns the HI/LO architectural registers used by MFHI, MFLO, MTHI and MTLO. While an operation is in flight it asserts `stall`, which the pipeline uses to freeze IF/ID/EX whenever an instruction needs the unit or HI/LO. It sits beside the ALU and takes its operands from the same forwarded `data_1`/`data_2` values.

---
 rtl/muldiv_pkg.sv | 21 ++
 rtl/muldiv_step.sv | 29 ++
 rtl/muldiv_ctrl.sv | 136 +++++++++++++
 3 files changed

// File: rtl/muldiv_pkg.sv
// Shared types for the iterative multiply/divide unit.
// Op and state encodings plus the HI/LO select values.
package muldiv_pkg;

  typedef enum logic [1:0] {
    OP_MULT  = 2'b00,
    OP_MULTU = 2'b01,
    OP_DIV   = 2'b10,
    OP_DIVU  = 2'b11
  } op_t;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    CALC = 2'b01,
    FIX  = 2'b10
  } state_t;

  localparam logic HL_LO = 1'b0;
  localparam logic HL_HI = 1'b1;

endpackage

// File: rtl/muldiv_step.sv
// One combinational iteration: shift-add multiply or restoring divide, zero latency.
// No flow control; the caller decides when the result is registered.
module muldiv_step #(
  parameter int WIDTH = 32
) (
  input  logic               is_div,
  input  logic [2*WIDTH-1:0] acc,
  input  logic [WIDTH-1:0]   opnd,
  output logic [2*WIDTH-1:0] acc_next
);

  logic [WIDTH:0] msum;
  logic [WIDTH:0] rem;
  logic [WIDTH:0] diff;

  // acc = {partial product, multiplier} for multiply, {remainder, dividend/quotient} for divide
  always_comb begin
    msum = {1'b0, acc[2*WIDTH-1:WIDTH]} + (acc[0] ? {1'b0, opnd} : '0);
    rem  = {acc[2*WIDTH-1:WIDTH], acc[WIDTH-1]};
    diff = rem - {1'b0, opnd};
    if (!is_div)
      acc_next = {msum, acc[WIDTH-1:1]};
    else if (!diff[WIDTH])
      acc_next = {diff[WIDTH-1:0], acc[WIDTH-2:0], 1'b1};
    else
      acc_next = {rem[WIDTH-1:0], acc[WIDTH-2:0], 1'b0};
  end

endmodule

// File: rtl/muldiv_ctrl.sv
// MULT/MULTU/DIV/DIVU sequencer owning HI/LO; 34 cycles from start to readable result.
// Requests arriving while busy raise stall and are ignored until busy drops.
module muldiv_ctrl
  import muldiv_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] data_1,
  input  logic [WIDTH-1:0] data_2,
  input  logic             mf_req,
  input  logic             mt_we,
  input  logic             hl_sel,
  output logic [WIDTH-1:0] hl_out,
  output logic             busy,
  output logic             stall,
  output logic             done
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  state_t             state;
  op_t                op_r;
  logic [CW-1:0]      cnt;
  logic [2*WIDTH-1:0] acc;
  logic [2*WIDTH-1:0] acc_next;
  logic [WIDTH-1:0]   opnd;
  logic [WIDTH-1:0]   raw_a;
  logic [WIDTH-1:0]   hi;
  logic [WIDTH-1:0]   lo;
  logic               neg_res;
  logic               neg_rem;
  logic               div0;

  logic               op_signed;
  logic               a_neg;
  logic               b_neg;
  logic [WIDTH-1:0]   abs_a;
  logic [WIDTH-1:0]   abs_b;
  logic               run_div;
  logic [2*WIDTH-1:0] prod_fix;
  logic [WIDTH-1:0]   q_fix;
  logic [WIDTH-1:0]   r_fix;

  assign hl_out = (hl_sel == HL_HI) ? hi : lo;
  assign stall  = busy & (start | mf_req | mt_we);

  assign op_signed = (op_t'(op) == OP_MULT) || (op_t'(op) == OP_DIV);
  assign a_neg     = op_signed & data_1[WIDTH-1];
  assign b_neg     = op_signed & data_2[WIDTH-1];
  assign abs_a     = a_neg ? (~data_1 + 1'b1) : data_1;
  assign abs_b     = b_neg ? (~data_2 + 1'b1) : data_2;
  assign run_div   = (op_r == OP_DIV) || (op_r == OP_DIVU);

  always_comb begin
    prod_fix = neg_res ? (~acc + 1'b1) : acc;
    q_fix    = neg_res ? (~acc[WIDTH-1:0] + 1'b1) : acc[WIDTH-1:0];
    r_fix    = neg_rem ? (~acc[2*WIDTH-1:WIDTH] + 1'b1) : acc[2*WIDTH-1:WIDTH];
  end

  muldiv_step #(.WIDTH(WIDTH)) u_step (
    .is_div   (run_div),
    .acc      (acc),
    .opnd     (opnd),
    .acc_next (acc_next)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      op_r    <= OP_MULT;
      cnt     <= '0;
      acc     <= '0;
      opnd    <= '0;
      raw_a   <= '0;
      hi      <= '0;
      lo      <= '0;
      neg_res <= 1'b0;
      neg_rem <= 1'b0;
      div0    <= 1'b0;
      busy    <= 1'b0;
      done    <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start && !stall) begin
            // Multiplication commutes, so both op kinds load the same operand layout
            acc     <= {{WIDTH{1'b0}}, abs_a};
            opnd    <= abs_b;
            raw_a   <= data_1;
            op_r    <= op_t'(op);
            neg_res <= a_neg ^ b_neg;
            neg_rem <= a_neg;
            div0    <= (data_2 == '0);
            cnt     <= '0;
            busy    <= 1'b1;
            state   <= CALC;
          end else if (mt_we) begin
            if (hl_sel == HL_HI) hi <= data_1;
            else                 lo <= data_1;
          end
        end
        CALC: begin
          acc <= acc_next;
          cnt <= cnt + CW'(1);
          if (cnt == LAST) state <= FIX;
        end
        FIX: begin
          if (!run_div) begin
            hi <= prod_fix[2*WIDTH-1:WIDTH];
            lo <= prod_fix[WIDTH-1:0];
          end else if (div0) begin
            hi <= raw_a;
            lo <= '1;
          end else begin
            hi <= r_fix;
            lo <= q_fix;
          end
          busy  <= 1'b0;
          done  <= 1'b1;
          state <= IDLE;
        end
        default: begin
          busy  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule
